tt_um_unsigned_multiplier_seq: RTL



---
 rtl/tt_mul_pkg.sv | 20 ++
 rtl/mul_shift_add_core.sv | 62 ++++++
 rtl/tt_um_unsigned_multiplier_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/tt_mul_pkg.sv
// Shared definitions for the shift-add multiplier tile that rebuilds a
// dividend from the divider tile's quotient, divisor and remainder.
package tt_mul_pkg;

    localparam int N = 4;

    localparam int START_BIT = 4;
    localparam int BUSY_BIT  = 5;
    localparam int DONE_BIT  = 6;
    localparam int ERR_BIT   = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_shift_add_core.sv
// Generic N-bit shift-add multiply-accumulate datapath: result = mplier * mcand + addend.
// One partial product is folded in per step; 'last' flags the final step.
module mul_shift_add_core #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   mplier_in,
    input  logic [N-1:0]   mcand_in,
    input  logic [N-1:0]   addend_in,
    output logic           last,
    output logic [2*N-1:0] result
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            // Seeding the accumulator with the addend folds "+ R" in for free.
            acc_d    = {{N{1'b0}}, addend_in};
            mcand_d  = {{N{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            cnt_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last   = (cnt_q == CW'(N - 1));
    assign result = acc_q;

endmodule

// File: rtl/tt_um_unsigned_multiplier_seq.sv
// TinyTapeout tile: dividend = Q * D + R via a sequential multiplier, with a
// flag for divider results that are not canonical (D == 0 or R >= D).
module tt_um_unsigned_multiplier_seq
    import tt_mul_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t         state_q, state_d;
    logic           start_q;
    logic [2*N-1:0] uo_q, uo_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           start_evt;
    logic           busy;
    logic           core_load, core_step, core_last;
    logic [2*N-1:0] core_result;

    logic [N-1:0]   q_in, d_in, r_in;
    logic           unused_uio;

    assign q_in       = ui_in[7:4];
    assign d_in       = ui_in[3:0];
    assign r_in       = uio_in[3:0];
    assign unused_uio = &{1'b0, uio_in[7:5]};

    assign start_evt = ena && uio_in[START_BIT] && !start_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        uo_d      = uo_q;
        done_d    = done_q;
        err_d     = err_q;
        core_load = 1'b0;
        core_step = 1'b0;
        // A disabled tile takes no transitions, so the datapath freezes with it.
        if (ena) begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                    if (start_evt) begin
                        core_load = 1'b1;
                        err_d     = (d_in == '0) || (r_in >= d_in);
                        state_d   = MUL;
                    end
                end
                MUL: begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    uo_d    = core_result;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            uo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            start_q <= uio_in[START_BIT];
            uo_q    <= uo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    mul_shift_add_core #(.N(N)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .step      (core_step),
        .mplier_in (q_in),
        .mcand_in  (d_in),
        .addend_in (r_in),
        .last      (core_last),
        .result    (core_result)
    );

    always_comb begin
        uio_out           = '0;
        uio_out[BUSY_BIT] = busy;
        uio_out[DONE_BIT] = done_q;
        uio_out[ERR_BIT]  = err_q;
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE_MASK;

endmodule
